// File: rtl/screen_sequencer_if.sv
// Screen sequencer bus: game-side inputs and screen/tally outputs, clock and reset kept outside.
// master drives the inputs (game logic/VGA side); slave is the sequencer.
interface screen_sequencer_if #(
  parameter int WIN_W = 4
);
  logic             frame_tick;
  logic             btn_start;
  logic             game_over;
  logic [1:0]       winner;
  logic             ceWS;
  logic             cePS;
  logic             ceSS;
  logic             new_game;
  logic [1:0]       winner_latched;
  logic [WIN_W-1:0] wins_x;
  logic [WIN_W-1:0] wins_o;

  modport master (
    output frame_tick, btn_start, game_over, winner,
    input  ceWS, cePS, ceSS, new_game, winner_latched, wins_x, wins_o
  );

  modport slave (
    input  frame_tick, btn_start, game_over, winner,
    output ceWS, cePS, ceSS, new_game, winner_latched, wins_x, wins_o
  );
endinterface

// File: rtl/screen_sequencer.sv
// TicTacToe screen FSM (welcome/play/score) with session win tallies and idle timeout.
// All outputs registered, 1 cycle after the sampled input; no backpressure, inputs are levels/pulses.
module screen_sequencer #(
  parameter int HOLD_FRAMES    = 60,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int CNT_W          = 10,
  parameter int WIN_W          = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  screen_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    WELCOME = 2'b00,
    PLAY    = 2'b01,
    SCORE   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_FRAMES);
  localparam logic [WIN_W-1:0] WIN_MAX   = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       wl, wl_nxt;
  logic [WIN_W-1:0] wx, wx_nxt, wo, wo_nxt;
  logic             ng_nxt;
  logic             btn_q;
  logic             start_rise;
  logic             ce_ws_q, ce_ps_q, ce_ss_q, ng_q;

  // btn_q resets high so a button held through reset is not seen as a press.
  assign start_rise = bus.btn_start & ~btn_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= WELCOME;
      cnt     <= '0;
      wl      <= '0;
      wx      <= '0;
      wo      <= '0;
      btn_q   <= 1'b1;
      ce_ws_q <= 1'b1;
      ce_ps_q <= 1'b0;
      ce_ss_q <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wl      <= wl_nxt;
      wx      <= wx_nxt;
      wo      <= wo_nxt;
      btn_q   <= bus.btn_start;
      ce_ws_q <= (state_nxt == WELCOME);
      ce_ps_q <= (state_nxt == PLAY);
      ce_ss_q <= (state_nxt == SCORE);
      ng_q    <= ng_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wl_nxt    = wl;
    wx_nxt    = wx;
    wo_nxt    = wo;
    ng_nxt    = 1'b0;
    case (state)
      WELCOME: begin
        if (start_rise) begin
          state_nxt = PLAY;
          ng_nxt    = 1'b1;
        end
      end
      PLAY: begin
        if (bus.game_over) begin
          state_nxt = SCORE;
          wl_nxt    = bus.winner;
          cnt_nxt   = '0;
          if (bus.winner == 2'b01 && wx != WIN_MAX) wx_nxt = wx + 1'b1;
          if (bus.winner == 2'b10 && wo != WIN_MAX) wo_nxt = wo + 1'b1;
        end
      end
      SCORE: begin
        // Hold check uses the count before this cycle's tick; start beats timeout.
        if (start_rise && cnt >= HOLD_C) begin
          state_nxt = PLAY;
          ng_nxt    = 1'b1;
        end else if (cnt == TIMEOUT_C) begin
          state_nxt = WELCOME;
          wl_nxt    = '0;
          wx_nxt    = '0;
          wo_nxt    = '0;
        end else if (bus.frame_tick && cnt < TIMEOUT_C) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = WELCOME;
    endcase
  end

  assign bus.ceWS           = ce_ws_q;
  assign bus.cePS           = ce_ps_q;
  assign bus.ceSS           = ce_ss_q;
  assign bus.new_game       = ng_q;
  assign bus.winner_latched = wl;
  assign bus.wins_x         = wx;
  assign bus.wins_o         = wo;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: reset, start, hold window, saturation, timeout, async reset.
module tb_screen_sequencer;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  screen_sequencer_if #(.WIN_W(4)) bus ();

  screen_sequencer #(
    .HOLD_FRAMES(60), .TIMEOUT_FRAMES(600), .CNT_W(10), .WIN_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen enables must be exactly one-hot in every cycle.
  always @(negedge clk) begin
    n_total++;
    if (!$onehot({bus.ceWS, bus.cePS, bus.ceSS}))
      $display("FAIL onehot t=%0t got=%b%b%b want one-hot", $time, bus.ceWS, bus.cePS, bus.ceSS);
    else n_pass++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.btn_start = 1'b1;
    repeat (3) step();
    n_total++; if (bus.ceWS !== 1'b1) $display("FAIL reset_ceWS got=%b want=1", bus.ceWS); else n_pass++;
    n_total++; if (bus.cePS !== 1'b0) $display("FAIL reset_cePS got=%b want=0", bus.cePS); else n_pass++;
    n_total++; if (bus.wins_x !== 4'd0 || bus.wins_o !== 4'd0)
      $display("FAIL reset_tally got=%0d/%0d want=0/0", bus.wins_x, bus.wins_o); else n_pass++;
    n_total++; if (bus.winner_latched !== 2'b00) $display("FAIL reset_latched got=%b want=00", bus.winner_latched); else n_pass++;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (bus.new_game !== 1'b0 || bus.ceWS !== 1'b1)
        $display("FAIL held_btn_no_press got ng=%b ws=%b want ng=0 ws=1", bus.new_game, bus.ceWS);
      else n_pass++;
    end
    bus.btn_start = 1'b0;
    step();
  endtask

  task automatic test_start();
    bus.btn_start = 1'b1;
    step();
    n_total++; if (bus.cePS !== 1'b1 || bus.ceWS !== 1'b0)
      $display("FAIL start_play got ps=%b ws=%b want ps=1 ws=0", bus.cePS, bus.ceWS); else n_pass++;
    n_total++; if (bus.new_game !== 1'b1) $display("FAIL start_new_game got=%b want=1", bus.new_game); else n_pass++;
    bus.btn_start = 1'b0;
    step();
    n_total++; if (bus.new_game !== 1'b0) $display("FAIL new_game_single got=%b want=0", bus.new_game); else n_pass++;
    n_total++; if (bus.cePS !== 1'b1) $display("FAIL stay_play got=%b want=1", bus.cePS); else n_pass++;
  endtask

  task automatic test_score_hold();
    bus.game_over = 1'b1; bus.winner = 2'b01;
    step();
    bus.game_over = 1'b0; bus.winner = 2'b00;
    n_total++; if (bus.ceSS !== 1'b1) $display("FAIL score_enter got=%b want=1", bus.ceSS); else n_pass++;
    n_total++; if (bus.winner_latched !== 2'b01) $display("FAIL score_latched got=%b want=01", bus.winner_latched); else n_pass++;
    n_total++; if (bus.wins_x !== 4'd1) $display("FAIL score_wins_x got=%0d want=1", bus.wins_x); else n_pass++;
    repeat (30) tick();
    bus.btn_start = 1'b1;
    step();
    bus.btn_start = 1'b0;
    n_total++; if (bus.ceSS !== 1'b1 || bus.new_game !== 1'b0)
      $display("FAIL press_frame30 got ss=%b ng=%b want ss=1 ng=0", bus.ceSS, bus.new_game); else n_pass++;
    step();
    repeat (29) tick();
    // Press at count 59 and keep holding past the hold window: must not be queued.
    bus.btn_start = 1'b1;
    step();
    n_total++; if (bus.ceSS !== 1'b1) $display("FAIL press_frame59 got=%b want ss=1", bus.ceSS); else n_pass++;
    tick(); tick();
    n_total++; if (bus.ceSS !== 1'b1 || bus.new_game !== 1'b0)
      $display("FAIL press_not_queued got ss=%b ng=%b want ss=1 ng=0", bus.ceSS, bus.new_game); else n_pass++;
    bus.btn_start = 1'b0;
    step();
    bus.btn_start = 1'b1;
    step();
    bus.btn_start = 1'b0;
    n_total++; if (bus.cePS !== 1'b1 || bus.new_game !== 1'b1)
      $display("FAIL press_frame61 got ps=%b ng=%b want ps=1 ng=1", bus.cePS, bus.new_game); else n_pass++;
    n_total++; if (bus.winner_latched !== 2'b01) $display("FAIL replay_latched got=%b want=01", bus.winner_latched); else n_pass++;
    step();
  endtask

  task automatic test_saturate();
    for (int i = 2; i <= 16; i++) begin
      bus.game_over = 1'b1; bus.winner = 2'b01;
      step();
      bus.game_over = 1'b0;
      n_total++;
      if (bus.wins_x !== 4'((i > 15) ? 15 : i))
        $display("FAIL sat_wins_x win=%0d got=%0d want=%0d", i, bus.wins_x, (i > 15) ? 15 : i);
      else n_pass++;
      repeat (60) tick();
      bus.btn_start = 1'b1; step();
      bus.btn_start = 1'b0;
      n_total++; if (bus.cePS !== 1'b1) $display("FAIL sat_replay win=%0d got=%b want=1", i, bus.cePS); else n_pass++;
      step();
    end
    bus.game_over = 1'b1; bus.winner = 2'b11;
    step();
    bus.game_over = 1'b0;
    n_total++; if (bus.wins_x !== 4'd15 || bus.wins_o !== 4'd0)
      $display("FAIL draw_tally got=%0d/%0d want=15/0", bus.wins_x, bus.wins_o); else n_pass++;
    n_total++; if (bus.winner_latched !== 2'b11) $display("FAIL draw_latched got=%b want=11", bus.winner_latched); else n_pass++;
    repeat (60) tick();
    bus.btn_start = 1'b1; step();
    bus.btn_start = 1'b0; step();
    bus.game_over = 1'b1; bus.winner = 2'b10;
    step();
    bus.game_over = 1'b0;
    n_total++; if (bus.wins_o !== 4'd1 || bus.wins_x !== 4'd15)
      $display("FAIL o_win_tally got=%0d/%0d want=15/1", bus.wins_x, bus.wins_o); else n_pass++;
    n_total++; if (bus.winner_latched !== 2'b10) $display("FAIL o_win_latched got=%b want=10", bus.winner_latched); else n_pass++;
  endtask

  task automatic test_timeout();
    repeat (599) tick();
    step();
    n_total++; if (bus.ceSS !== 1'b1) $display("FAIL timeout_early_599 got=%b want ss=1", bus.ceSS); else n_pass++;
    tick();
    n_total++; if (bus.ceSS !== 1'b1) $display("FAIL timeout_early_600 got=%b want ss=1", bus.ceSS); else n_pass++;
    step();
    n_total++; if (bus.ceWS !== 1'b1) $display("FAIL timeout_welcome got=%b want=1", bus.ceWS); else n_pass++;
    n_total++; if (bus.wins_x !== 4'd0 || bus.wins_o !== 4'd0)
      $display("FAIL timeout_tally got=%0d/%0d want=0/0", bus.wins_x, bus.wins_o); else n_pass++;
    n_total++; if (bus.winner_latched !== 2'b00) $display("FAIL timeout_latched got=%b want=00", bus.winner_latched); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.btn_start = 1'b1; step();
    bus.btn_start = 1'b0; step();
    bus.game_over = 1'b1; bus.winner = 2'b10;
    step();
    bus.game_over = 1'b0;
    n_total++; if (bus.wins_o !== 4'd1) $display("FAIL b2b_o_win got=%0d want=1", bus.wins_o); else n_pass++;
    repeat (600) tick();
    bus.btn_start = 1'b1;
    step();
    n_total++; if (bus.cePS !== 1'b1 || bus.new_game !== 1'b1)
      $display("FAIL start_on_timeout got ps=%b ng=%b want ps=1 ng=1", bus.cePS, bus.new_game); else n_pass++;
    n_total++; if (bus.wins_o !== 4'd1 || bus.winner_latched !== 2'b10)
      $display("FAIL start_on_timeout_kept got o=%0d wl=%b want o=1 wl=10", bus.wins_o, bus.winner_latched); else n_pass++;
    // game_over during the new_game cycle is still honoured.
    bus.btn_start = 1'b0;
    bus.game_over = 1'b1; bus.winner = 2'b01;
    step();
    bus.game_over = 1'b0;
    n_total++; if (bus.ceSS !== 1'b1 || bus.wins_x !== 4'd1)
      $display("FAIL over_in_new_game got ss=%b x=%0d want ss=1 x=1", bus.ceSS, bus.wins_x); else n_pass++;
  endtask

  task automatic test_async_reset();
    repeat (60) tick();
    bus.btn_start = 1'b1; step();
    bus.btn_start = 1'b0;
    n_total++; if (bus.cePS !== 1'b1) $display("FAIL pre_reset_play got=%b want=1", bus.cePS); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (bus.ceWS !== 1'b1 || bus.cePS !== 1'b0 || bus.new_game !== 1'b0)
      $display("FAIL async_reset got ws=%b ps=%b ng=%b want 1 0 0", bus.ceWS, bus.cePS, bus.new_game); else n_pass++;
    n_total++; if (bus.wins_x !== 4'd0 || bus.wins_o !== 4'd0)
      $display("FAIL async_reset_tally got=%0d/%0d want=0/0", bus.wins_x, bus.wins_o); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
    n_total++; if (bus.ceWS !== 1'b1 || bus.new_game !== 1'b0)
      $display("FAIL post_reset got ws=%b ng=%b want ws=1 ng=0", bus.ceWS, bus.new_game); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn_start = 1'b1;
    bus.game_over = 1'b0;
    bus.winner = 2'b00;
    test_reset();
    test_start();
    test_score_hold();
    test_saturate();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
